// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
// Vectors are [31:0]; big-endian lanes put byte 0 in bits [31:24].
package dmem_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned LANE_ADDR_LSB = 30;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  // Byte wins over half; neither means a full word.
  function automatic size_t decode_size(input logic is_byte, input logic is_half);
    if (is_byte) return SZ_BYTE;
    if (is_half) return SZ_HALF;
    return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] lane);
    return ((sz == SZ_HALF) && lane[0]) || ((sz == SZ_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]        lane_i,
  input  size_t             size_i,
  input  logic              sext_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic [WORD_W-1:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[31:24];
    half_sel = lane_i[1] ? word_i[15:0] : word_i[31:16];
    rdata_o  = word_i;
    merged_o = word_i;
    case (lane_i)
      2'd0:    byte_sel = word_i[31:24];
      2'd1:    byte_sel = word_i[23:16];
      2'd2:    byte_sel = word_i[15:8];
      default: byte_sel = word_i[7:0];
    endcase
    case (size_i)
      SZ_BYTE: begin
        rdata_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
        case (lane_i)
          2'd0:    merged_o[31:24] = wdata_i[7:0];
          2'd1:    merged_o[23:16] = wdata_i[7:0];
          2'd2:    merged_o[15:8]  = wdata_i[7:0];
          default: merged_o[7:0]   = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        rdata_o = {{16{sext_i & half_sel[15]}}, half_sel};
        if (lane_i[1]) merged_o[15:0]  = wdata_i[15:0];
        else           merged_o[31:16] = wdata_i[15:0];
      end
      default: begin
        rdata_o  = word_i;
        merged_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// DMEM controller: turns processor loads/stores into aligned word
// transactions on a req/ack backing memory, with RMW for sub-word stores.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              proc_req,
  input  logic [WORD_W-1:0] proc_addr,
  input  logic              proc_we,
  input  logic              proc_byte,
  input  logic              proc_half,
  input  logic              proc_sext,
  input  logic [WORD_W-1:0] proc_wdata,
  output logic [WORD_W-1:0] proc_rdata,
  output logic              proc_stall,
  output logic              proc_misaligned,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam int unsigned LANE_HI = WORD_W - 1 - LANE_ADDR_LSB;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  size_t             size_q, size_d;
  logic              sext_q, sext_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] merge_q, merge_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  logic              accept_c;
  logic              in_mem_c;
  size_t             req_size_c;
  logic              req_mis_c;
  logic              tmo_c;
  logic [WORD_W-1:0] lane_rdata;
  logic [WORD_W-1:0] lane_merged;

  dmem_lane_unit u_lane (
    .lane_i   (addr_q[LANE_HI -: 2]),
    .size_i   (size_q),
    .sext_i   (sext_q),
    .word_i   (mem_rdata),
    .wdata_i  (wdata_q),
    .rdata_o  (lane_rdata),
    .merged_o (lane_merged)
  );

  // Next-state, hold-register capture and phase completion.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q + CNT_W'(1);
    mis_d      = 1'b0;
    err_d      = 1'b0;
    accept_c   = 1'b0;
    req_size_c = decode_size(proc_byte, proc_half);
    req_mis_c  = is_misaligned(req_size_c, proc_addr[LANE_HI -: 2]);
    tmo_c      = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (proc_req) begin
          accept_c = 1'b1;
          addr_d   = proc_addr;
          we_d     = proc_we;
          size_d   = req_size_c;
          sext_d   = proc_sext;
          wdata_d  = proc_wdata;
          if (req_mis_c) begin
            state_d = DONE;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else if (!proc_we) begin
            state_d = RD;
          end else if (req_size_c == SZ_WORD) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD: begin
        if (mem_ack) begin
          rdata_d = lane_rdata;
          state_d = DONE;
        end else if (tmo_c) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      RMW_RD: begin
        if (mem_ack) begin
          merge_d = lane_merged;
          state_d = RMW_WR;
        end else if (tmo_c) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WR, RMW_WR: begin
        if (mem_ack) begin
          state_d = DONE;
        end else if (tmo_c) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Each memory phase starts its timeout window from zero.
    if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs decode straight from the state register so reset drops them at once.
  assign in_mem_c        = (state_q == RD) || (state_q == WR) ||
                           (state_q == RMW_RD) || (state_q == RMW_WR);
  assign mem_req         = in_mem_c;
  assign mem_we          = (state_q == WR) || (state_q == RMW_WR);
  assign mem_addr        = in_mem_c ? {addr_q[WORD_W-1:2], 2'b00} : '0;
  assign mem_wdata       = (state_q == WR)     ? wdata_q :
                           (state_q == RMW_WR) ? merge_q : '0;
  assign proc_stall      = in_mem_c | accept_c;
  assign proc_rdata      = rdata_q;
  assign proc_misaligned = mis_q;
  assign bus_err         = err_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table plus hand-written
// sequences for delayed ack, timeout and reset mid-transaction.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        proc_req, proc_we, proc_byte, proc_half, proc_sext;
  logic [31:0] proc_addr, proc_wdata, proc_rdata;
  logic        proc_stall, proc_misaligned, bus_err;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Backing memory model
  logic [31:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic        ack_en = 1'b1;
  logic        wr_ack_en = 1'b1;
  logic        force_ack = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_addr = '0;

  dmem_ctrl #(.TIMEOUT(8)) dut (
    .clock           (clk),
    .reset           (rst_n),
    .proc_req        (proc_req),
    .proc_addr       (proc_addr),
    .proc_we         (proc_we),
    .proc_byte       (proc_byte),
    .proc_half       (proc_half),
    .proc_sext       (proc_sext),
    .proc_wdata      (proc_wdata),
    .proc_rdata      (proc_rdata),
    .proc_stall      (proc_stall),
    .proc_misaligned (proc_misaligned),
    .bus_err         (bus_err),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[8'(mem_addr >> 2)];
  assign mem_ack   = force_ack ||
                     (mem_req && ack_en && (!mem_we || wr_ack_en) && (wait_cnt >= ack_delay));

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (mem_req && mem_ack) begin
      last_addr <= mem_addr;
      if (mem_we) begin
        mem[8'(mem_addr >> 2)] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preset(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_idx = 8'(a >> 2);
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Issue one access; returns at the DONE cycle (negedge + 1) with the stall count.
  task automatic access(input logic [31:0] a, input logic we, input logic b, input logic h,
                        input logic s, input logic [31:0] wd, output int stalls);
    logic        done;
    logic        p_req, p_ack, p_we, have_prev;
    logic [31:0] p_addr, p_wdata;
    done = 1'b0;
    have_prev = 1'b0;
    p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    stalls = 0;
    @(negedge clk);
    proc_addr = a; proc_we = we; proc_byte = b; proc_half = h;
    proc_sext = s; proc_wdata = wd; proc_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!proc_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (have_prev && p_req && !p_ack && mem_req) begin
        chk("mem_addr_stable", mem_addr, p_addr);
        chk("mem_wdata_stable", mem_wdata, p_wdata);
        chk("mem_we_stable", 32'(mem_we), 32'(p_we));
      end
      have_prev = 1'b1;
      p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
      p_addr = mem_addr; p_wdata = mem_wdata;
      @(posedge clk);
      #1 proc_req = 1'b0;
      @(negedge clk);
    end
    chk("access_completes", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we, b, h, s;
    logic [31:0] wdata, init;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    int          exp_stalls;
    logic        exp_mis;
    int          exp_rd, exp_wr;
    logic [31:0] exp_mem, exp_maddr;
  } vec_t;

  vec_t vt [14];

  initial begin
    int st, rd0, wr0;
    logic [31:0] wa;

    vt[0]  = '{32'h100, 0, 0, 0, 0, 32'h0, 32'h11223344, 1, 32'h11223344, 2, 0, 1, 0, 32'h11223344, 32'h100};
    vt[1]  = '{32'h200, 0, 1, 0, 1, 32'h0, 32'h80FF7F01, 1, 32'hFFFFFF80, 2, 0, 1, 0, 32'h80FF7F01, 32'h200};
    vt[2]  = '{32'h203, 0, 1, 0, 0, 32'h0, 32'h80FF7F01, 1, 32'h00000001, 2, 0, 1, 0, 32'h80FF7F01, 32'h200};
    vt[3]  = '{32'h202, 0, 0, 1, 1, 32'h0, 32'h80FF7F01, 1, 32'h00007F01, 2, 0, 1, 0, 32'h80FF7F01, 32'h200};
    vt[4]  = '{32'h200, 0, 0, 1, 1, 32'h0, 32'h80FF7F01, 1, 32'hFFFF80FF, 2, 0, 1, 0, 32'h80FF7F01, 32'h200};
    vt[5]  = '{32'h200, 0, 0, 1, 0, 32'h0, 32'h80FF7F01, 1, 32'h000080FF, 2, 0, 1, 0, 32'h80FF7F01, 32'h200};
    vt[6]  = '{32'h201, 0, 1, 0, 1, 32'h0, 32'h80FF7F01, 1, 32'hFFFFFFFF, 2, 0, 1, 0, 32'h80FF7F01, 32'h200};
    vt[7]  = '{32'h203, 0, 1, 1, 1, 32'h0, 32'h80FF7F01, 1, 32'h00000001, 2, 0, 1, 0, 32'h80FF7F01, 32'h200};
    vt[8]  = '{32'h041, 1, 1, 0, 0, 32'h00000012, 32'hAABBCCDD, 0, 32'h0, 3, 0, 1, 1, 32'hAA12CCDD, 32'h040};
    vt[9]  = '{32'h046, 1, 0, 1, 0, 32'h1234BEEF, 32'h55667788, 0, 32'h0, 3, 0, 1, 1, 32'h5566BEEF, 32'h044};
    vt[10] = '{32'h048, 1, 0, 0, 0, 32'hCAFEF00D, 32'h00000000, 0, 32'h0, 2, 0, 0, 1, 32'hCAFEF00D, 32'h048};
    vt[11] = '{32'h042, 1, 0, 0, 0, 32'hDEADBEEF, 32'h01020304, 1, 32'h0, 1, 1, 0, 0, 32'h01020304, 32'h0};
    vt[12] = '{32'h203, 0, 0, 1, 1, 32'h0, 32'h80FF7F01, 1, 32'h0, 1, 1, 0, 0, 32'h80FF7F01, 32'h0};
    vt[13] = '{32'h04F, 1, 1, 0, 0, 32'hFFFFFF77, 32'h00000000, 0, 32'h0, 3, 0, 1, 1, 32'h00000077, 32'h04C};

    rst_n = 1'b0;
    proc_req = 0; proc_we = 0; proc_byte = 0; proc_half = 0; proc_sext = 0;
    proc_addr = '0; proc_wdata = '0;
    #1;
    chk("rst_rdata", proc_rdata, 32'h0);
    chk("rst_stall", 32'(proc_stall), 32'h0);
    chk("rst_misaligned", 32'(proc_misaligned), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 14; i++) begin
      wa = vt[i].addr & 32'hFFFF_FFFC;
      preset(wa, vt[i].init);
      rd0 = rd_cnt; wr0 = wr_cnt;
      access(vt[i].addr, vt[i].we, vt[i].b, vt[i].h, vt[i].s, vt[i].wdata, st);
      chk($sformatf("v%0d_stalls", i), 32'(st), 32'(vt[i].exp_stalls));
      if (vt[i].chk_rd) chk($sformatf("v%0d_rdata", i), proc_rdata, vt[i].exp_rdata);
      chk($sformatf("v%0d_misaligned", i), 32'(proc_misaligned), 32'(vt[i].exp_mis));
      chk($sformatf("v%0d_bus_err", i), 32'(bus_err), 32'h0);
      chk($sformatf("v%0d_reads", i), 32'(rd_cnt - rd0), 32'(vt[i].exp_rd));
      chk($sformatf("v%0d_writes", i), 32'(wr_cnt - wr0), 32'(vt[i].exp_wr));
      chk($sformatf("v%0d_mem", i), mem[8'(wa >> 2)], vt[i].exp_mem);
      if (vt[i].exp_rd + vt[i].exp_wr > 0)
        chk($sformatf("v%0d_mem_addr", i), last_addr, vt[i].exp_maddr);
    end

    // Ack delayed by 5 cycles: stall held, bus stable, DONE right after ack
    preset(32'h104, 32'h0BADF00D);
    ack_delay = 5;
    access(32'h104, 0, 0, 0, 0, 32'h0, st);
    chk("delay_stalls", 32'(st), 32'd7);
    chk("delay_rdata", proc_rdata, 32'h0BADF00D);
    chk("delay_bus_err", 32'(bus_err), 32'h0);
    ack_delay = 0;

    // Timeout: 8 RD cycles without ack, then recovery
    ack_en = 1'b0;
    rd0 = rd_cnt;
    access(32'h108, 0, 0, 0, 0, 32'h0, st);
    chk("tmo_stalls", 32'(st), 32'd9);
    chk("tmo_bus_err", 32'(bus_err), 32'h1);
    chk("tmo_rdata", proc_rdata, 32'h0);
    chk("tmo_reads", 32'(rd_cnt - rd0), 32'h0);
    @(posedge clk); #1;
    chk("tmo_bus_err_pulse", 32'(bus_err), 32'h0);
    ack_en = 1'b1;
    preset(32'h10C, 32'h600DCAFE);
    access(32'h10C, 0, 0, 0, 0, 32'h0, st);
    chk("tmo_next_stalls", 32'(st), 32'd2);
    chk("tmo_next_rdata", proc_rdata, 32'h600DCAFE);

    // Reset during RMW_WR followed by a late ack
    preset(32'h050, 32'h11111111);
    wr0 = wr_cnt;
    wr_ack_en = 1'b0;
    @(negedge clk);
    proc_addr = 32'h051; proc_we = 1; proc_byte = 1; proc_half = 0;
    proc_sext = 0; proc_wdata = 32'h00000099; proc_req = 1'b1;
    @(posedge clk); #1 proc_req = 1'b0;
    @(posedge clk); #1;
    chk("rmw_wr_req", 32'(mem_req), 32'h1);
    chk("rmw_wr_we", 32'(mem_we), 32'h1);
    chk("rmw_wr_wdata", mem_wdata, 32'h11991111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'h0);
    chk("async_rst_stall", 32'(proc_stall), 32'h0);
    chk("async_rst_mem_wdata", mem_wdata, 32'h0);
    force_ack = 1'b1;
    wr_ack_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("late_ack_mem_req", 32'(mem_req), 32'h0);
    chk("late_ack_stall", 32'(proc_stall), 32'h0);
    chk("late_ack_bus_err", 32'(bus_err), 32'h0);
    @(posedge clk); #1 force_ack = 1'b0;
    chk("rst_mem_unchanged", mem[8'(32'h050 >> 2)], 32'h11111111);
    chk("rst_no_write", 32'(wr_cnt - wr0), 32'h0);
    access(32'h050, 0, 0, 0, 0, 32'h0, st);
    chk("post_rst_stalls", 32'(st), 32'd2);
    chk("post_rst_rdata", proc_rdata, 32'h11111111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller between the processor's DMEM port and a word-wide backing memory with variable latency and a req/ack handshake.
- Turns byte, half-word and word loads and stores into aligned word transactions. Sub-word stores use read-modify-write.
- Loads are returned right-justified, sign- or zero-extended.
- Drives a stall back to the pipeline while a transaction is outstanding.

Parameters:
TIMEOUT, 64, cycles spent waiting for mem_ack in one memory phase before the access is aborted with bus_err.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
proc_req  in  1  access request from MEM stage
proc_addr  in  [0:31]  byte address; bit 0 is the MSB
proc_we  in  1  1 = store, 0 = load
proc_byte  in  1  byte access
proc_half  in  1  half-word access
proc_sext  in  1  sign-extend a sub-word load
proc_wdata  in  [0:31]  store data, right-justified
proc_rdata  out  [0:31]  load result, valid in DONE
proc_stall  out  1  hold the pipeline
proc_misaligned  out  1  one-cycle pulse: misaligned access was dropped
bus_err  out  1  one-cycle pulse: memory timeout
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  [0:31]  word address; [30:31] always 0
mem_wdata  out  [0:31]  memory write data
mem_rdata  in  [0:31]  memory read data
mem_ack  in  1  memory completion

Behaviour:
- Reset (reset=0, async):
  - state goes to IDLE.
  - All outputs are 0: proc_rdata, proc_stall, proc_misaligned, bus_err, mem_req, mem_we, mem_addr, mem_wdata.
  - Reset mid-transaction drops mem_req immediately. A late mem_ack arriving after reset is ignored.
- Size decode: byte wins if proc_byte=1, else half if proc_half=1, else word.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- Accept rule: in IDLE or DONE, with proc_req=1:
  - Capture addr, we, size, sext and wdata into hold registers.
  - proc_stall=1 combinationally in this cycle.
  - Next state:
    - Misaligned (half with addr[31]=1, or word with addr[30:31]!=0) -> DONE. No memory access, proc_misaligned pulse in DONE, proc_rdata=0.
    - Load -> RD.
    - Word store -> WR.
    - Sub-word store -> RMW_RD.
  - Without proc_req in DONE -> IDLE.
- Handshake:
  - In RD, WR, RMW_RD and RMW_WR: mem_req=1, with mem_addr = {addr[0:29],2'b00}.
  - mem_we and mem_wdata are held stable until a cycle with mem_ack=1.
  - mem_ack while mem_req=0 is ignored.
- Phase transitions on mem_ack:
  - RD: extract the lane from mem_rdata, register it into proc_rdata -> DONE.
  - RMW_RD: merge into a registered word -> RMW_WR.
  - WR and RMW_WR -> DONE.
- proc_stall is 1 in every state except IDLE and DONE. It is 0 in DONE unless a new request is accepted that cycle.
- Lanes are big-endian:
  - Byte k = addr[30:31] occupies bits [8k:8k+7].
  - Half h = addr[30] occupies bits [16h:16h+15].
- Load result:
  - Byte goes into [24:31], half into [16:31].
  - Upper bits are filled with the lane MSB if sext=1, else 0.
  - A word load passes through unchanged.
- Merge: proc_wdata[24:31] (byte) or proc_wdata[16:31] (half) replaces its lane. All other bits keep the read data.
- Timeout:
  - The counter clears on entry to each memory phase.
  - When it reaches TIMEOUT with no ack: pulse bus_err, drop mem_req, go to DONE.
  - A load that times out returns proc_rdata=0. A store that times out writes nothing further.
- Zero-wait latency (request accepted in cycle N):
  - Load or word store: DONE at N+2, stall high for 2 cycles.
  - Sub-word store: DONE at N+3, stall high for 3 cycles.
- proc_rdata holds its value until the next load completes.

Decomposition:
- Package dmem_pkg: state_t enum, size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD), constants WORD_W=32 and LANE_ADDR_LSB=30.
- Sub-module dmem_lane_unit: purely combinational lane extract/extend and merge. Inputs are addr[30:31], size, sext, word and wdata.

Test Plan:
- Word load of 0x11223344 at 0x100, immediate ack -> stall for 2 cycles, rdata=0x11223344 in DONE, one mem_req at 0x100.
- Sub-word loads, memory word 0x80FF7F01 at 0x200:
  - byte at 0x200 with sext -> 0xFFFFFF80
  - byte at 0x203 without sext -> 0x00000001
  - half at 0x202 with sext -> 0x00007F01
  - half at 0x200 with sext -> 0xFFFF80FF
- Byte store of 0x12 to 0x41, memory holds 0xAABBCCDD -> one read, then one write of 0xAA12CCDD at 0x40, stall for 3 cycles.
- Load with ack delayed 5 cycles -> mem_req, mem_addr and mem_we stable throughout, stall held, DONE in the cycle after ack.
- TIMEOUT=8 with no ack -> bus_err pulse after 8 RD cycles, rdata=0, controller accepts the next request, which completes normally.
- Misaligned word store to 0x42 -> no mem_req, misaligned pulse, memory unchanged.
- reset=0 during RMW_WR, then late ack -> mem_req drops asynchronously, memory unchanged, state IDLE.
